matrix_mult_seq: RTL and testbench
==================================

# matrix_mult_seq

Sequential matrix-multiply engine that computes C = A × B for square `order`×`order` matrices of `bitwidth`-bit elements. It sits directly downstream of the AXI memory/peripheral model. That model assembles A and B from CPU writes into flattened buses and drives `enable`. It exposes `rdy` and C back to the CPU at its status and C windows. The engine uses one multiplier and performs one multiply-accumulate per cycle, trading latency for area.

## Interface
Parameters:
- `order`, default 2: matrix dimension N; legal range 1..16.
- `bitwidth`, default 32: element width W in bits.

Ports:
- `clk`  input  1  — the block's only clock; all state updates on its rising edge.
- `reset`  input  1  — synchronous, active-high reset.
- `enable`  input  1  — start request, sampled in IDLE.
- `matAarg`  input  [0:N*N*W-1]  — flattened A; element (r,c) at `[W*(r*N+c) +: W]`.
- `matBarg`  input  [0:N*N*W-1]  — flattened B, same layout as A.
- `matCarg`  output  [0:N*N*W-1]  — flattened C, registered, same layout as A.
- `rdy`  output  1  — result valid, registered.
- `busy`  output  1  — computation in progress, registered.

## Operation
- Internal snapshot registers `sA`, `sB` (N*N*W each).
- Internal accumulator `acc` (W bits) and loop counters `i`, `j`, `k`, each clog2(N) bits, minimum 1 bit.
- States:
  - IDLE: entered on reset. If `enable`=1, capture `sA`←`matAarg` and `sB`←`matBarg`, clear `matCarg` to 0, clear `acc` and `i`, `j`, `k` to 0, set `rdy`=0 and `busy`=1, and go to MAC.
  - MAC: each cycle, sum = `acc` + `sA[i][k]`×`sB[k][j]`.
    - If k<N-1: `acc`←sum, k←k+1.
    - If k=N-1: `matCarg[i][j]`←sum, `acc`←0, k←0, and advance j. When j wraps, advance i.
    - On the cycle that writes the last element (i=j=k=N-1): set `busy`=0 and `rdy`=1, and go to DONE.
  - DONE: hold C and `rdy`=1. When `enable`=0, go to IDLE with `rdy` still 1.
- `rdy` remains 1 in IDLE until the next start. Software can poll it after dropping `enable`.
- Arithmetic:
  - Products are unsigned W×W; only the low W bits are kept.
  - Accumulation is modulo 2^W.
  - The result equals the low W bits of the two's-complement signed result, so signed operands also work.
- `enable` is level-sensitive but never re-triggers from DONE. A new run requires `enable` to go low, then high again.
- `enable` falling during MAC is ignored; the run completes.
- `matAarg` and `matBarg` changing after the start edge has no effect on the current run, because it uses the snapshot.
- `matCarg` is written only in MAC. In IDLE it holds the previous result until a start clears it.

## Timing
- Reset (synchronous, dominates `enable`):
  - State → IDLE.
  - `rdy`=0, `busy`=0, `matCarg`=0.
  - `acc`, counters, and snapshots = 0.
- Reset asserted mid-MAC aborts the run at that edge. No partial result is flagged valid.
- Start edge E: the first rising edge with state=IDLE, `enable`=1, `reset`=0.
  - `busy` is 1 and `rdy` is 0 after E.
- Latency: exactly N³ MAC cycles.
  - The last MAC edge is E+N³; `rdy` rises and `busy` falls after that edge.
  - order=2: `rdy` after E+8. order=3: `rdy` after E+27.
- Element write timing: C(i,j) becomes valid after edge E+N*(i*N+j+1).
- Throughput: back-to-back runs take ≥ N³+3 cycles — start, N³ MAC cycles, a DONE cycle with `enable`=0, then re-start from IDLE.
- `busy` and `rdy` are never both 1.
- N=1: a single MAC cycle; `rdy` after E+1.

## Test plan
- Basic product: order=2, W=32, A=[[1,2],[3,4]], B=[[5,6],[7,8]], `enable` pulsed high one cycle.
  - Expect C=[[19,22],[43,50]].
  - `busy` high for exactly 8 cycles; `rdy`=1 after E+8.
- Wrap-around: A=[[0xFFFFFFFF,0xFFFFFFFF],[0,0]], B=[[2,0],[3,0]].
  - Expect C00=0xFFFFFFFB and all other C elements 0.
- Snapshot isolation: start a run with the basic-product inputs, then change A to all 9 at E+2.
  - Expect C=[[19,22],[43,50]].
- Enable handshake: hold `enable`=1 through DONE for 20 cycles.
  - Expect no restart, with `rdy` and C stable.
  - Drop `enable` for 1 cycle, then raise it. Expect `rdy`→0 and C cleared at the new start edge, then a new result after 8 cycles.
- Reset mid-run: assert `reset` at E+4.
  - Expect next cycle `rdy`=0, `busy`=0, C=0, state IDLE.
  - A following start produces a correct result.
- Parameter sweep: order=3, W=16, A=identity, B=[[1..9]].
  - Expect C=B.
  - `rdy` after E+27.

Source files
------------

// File: rtl/matrix_mult_seq.sv
// matrix_mult_seq: sequential C = A x B engine for order x order matrices.
// One multiply-accumulate per cycle. The operands are snapshotted at start,
// so the caller may change its buses while a run is in progress.
module matrix_mult_seq #(
   parameter int order    = 2,
   parameter int bitwidth = 32
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             enable,
   input  logic [0:order*order*bitwidth-1]  matAarg,
   input  logic [0:order*order*bitwidth-1]  matBarg,
   output logic [0:order*order*bitwidth-1]  matCarg,
   output logic                             rdy,
   output logic                             busy
);

   localparam int N  = order;
   localparam int W  = bitwidth;
   localparam int MW = N * N * W;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [0:MW-1]   sa_q, sa_d;
   logic [0:MW-1]   sb_q, sb_d;
   logic [0:MW-1]   c_q, c_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [CW-1:0]   i_q, i_d;
   logic [CW-1:0]   j_q, j_d;
   logic [CW-1:0]   k_q, k_d;
   logic            rdy_q, rdy_d;
   logic            busy_q, busy_d;

   int              a_idx_s;
   int              b_idx_s;
   int              c_idx_s;
   logic [W-1:0]    a_el_s;
   logic [W-1:0]    b_el_s;
   logic [W-1:0]    prod_s;
   logic [W-1:0]    sum_s;

   // Operand fetch and the single modulo-2^W multiply-accumulate datapath.
   always_comb begin
      a_idx_s = int'(i_q) * N + int'(k_q);
      b_idx_s = int'(k_q) * N + int'(j_q);
      c_idx_s = int'(i_q) * N + int'(j_q);
      a_el_s  = sa_q[W*a_idx_s +: W];
      b_el_s  = sb_q[W*b_idx_s +: W];
      prod_s  = a_el_s * b_el_s;
      sum_s   = acc_q + prod_s;
   end

   // Next-state logic: IDLE -> MAC (N^3 cycles) -> DONE -> IDLE once enable drops.
   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      c_d     = c_q;
      acc_d   = acc_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      rdy_d   = rdy_q;
      busy_d  = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               sa_d    = matAarg;
               sb_d    = matBarg;
               c_d     = '0;
               acc_d   = '0;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               rdy_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = ST_MAC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MAC: begin
            if (k_q != LAST) begin
               acc_d = sum_s;
               k_d   = k_q + CW'(1);
            end else begin
               c_d[W*c_idx_s +: W] = sum_s;
               acc_d = '0;
               k_d   = '0;
               if (j_q != LAST) begin
                  j_d = j_q + CW'(1);
               end else begin
                  j_d = '0;
                  if (i_q != LAST) begin
                     i_d = i_q + CW'(1);
                  end else begin
                     i_d     = '0;
                     busy_d  = 1'b0;
                     rdy_d   = 1'b1;
                     state_d = ST_DONE;
                  end
               end
            end
         end
         ST_DONE: begin
            // Level-sensitive enable must drop before another run may start.
            if (!enable) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            rdy_d   = 1'b0;
         end
      endcase
   end

   // State register with synchronous reset that aborts any run in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         c_q     <= '0;
         acc_q   <= '0;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         c_q     <= c_d;
         acc_q   <= acc_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
      end
   end

   assign matCarg = c_q;
   assign rdy     = rdy_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Directed testbench for matrix_mult_seq: a 2x2/32-bit instance and a 3x3/16-bit instance.
module tb_matrix_mult_seq;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          en2 = 1'b0;
   logic          en3 = 1'b0;
   logic [0:127]  a2 = '0, b2 = '0, c2;
   logic [0:143]  a3 = '0, b3 = '0, c3;
   logic          rdy2, busy2, rdy3, busy3;
   logic [0:127]  basic_c, saved_c;

   int n_checks = 0;
   int n_errors = 0;

   matrix_mult_seq #(.order(2), .bitwidth(32)) u2 (
      .clk(clk), .reset(reset), .enable(en2),
      .matAarg(a2), .matBarg(b2), .matCarg(c2), .rdy(rdy2), .busy(busy2)
   );

   matrix_mult_seq #(.order(3), .bitwidth(16)) u3 (
      .clk(clk), .reset(reset), .enable(en3),
      .matAarg(a3), .matBarg(b3), .matCarg(c3), .rdy(rdy3), .busy(busy3)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   function automatic logic [0:127] pack2(input logic [31:0] e0, e1, e2, e3);
      pack2 = {e0, e1, e2, e3};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // From DONE or IDLE: drop enable for one edge, then produce start edge E.
   task automatic start2(input bit hold);
      en2 = 1'b0;
      tick();
      en2 = 1'b1;
      tick();
      if (!hold) en2 = 1'b0;
   endtask

   initial begin
      basic_c = pack2(32'd19, 32'd22, 32'd43, 32'd50);

      // Reset state
      tick();
      tick();
      chk("reset_flags2", {rdy2, busy2}, 2'b00);
      chk("reset_c2", c2, 128'd0);
      chk("reset_flags3", {rdy3, busy3}, 2'b00);
      chk("reset_c3", c3, 144'd0);
      reset = 1'b0;

      // Basic product with one-cycle enable pulse
      a2 = pack2(32'd1, 32'd2, 32'd3, 32'd4);
      b2 = pack2(32'd5, 32'd6, 32'd7, 32'd8);
      en2 = 1'b1;
      tick();
      en2 = 1'b0;
      chk("basic_start_flags", {rdy2, busy2}, 2'b01);
      for (int t = 1; t <= 7; t++) begin
         tick();
         chk($sformatf("basic_busy_E+%0d", t), {rdy2, busy2}, 2'b01);
         if (t == 2) chk("basic_c00_at_E+2", c2, pack2(32'd19, 32'd0, 32'd0, 32'd0));
      end
      tick();
      chk("basic_done_flags", {rdy2, busy2}, 2'b10);
      chk("basic_result", c2, basic_c);

      // Wrap-around arithmetic
      a2 = pack2(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
      b2 = pack2(32'd2, 32'd0, 32'd3, 32'd0);
      start2(1'b0);
      chk("wrap_start_cleared", {rdy2, busy2, c2}, {2'b01, 128'd0});
      for (int t = 1; t <= 8; t++) tick();
      chk("wrap_flags", {rdy2, busy2}, 2'b10);
      chk("wrap_result", c2, pack2(32'hFFFF_FFFB, 32'd0, 32'd0, 32'd0));

      // Snapshot isolation: A changes at E+2
      a2 = pack2(32'd1, 32'd2, 32'd3, 32'd4);
      b2 = pack2(32'd5, 32'd6, 32'd7, 32'd8);
      start2(1'b0);
      tick();
      tick();
      a2 = pack2(32'd9, 32'd9, 32'd9, 32'd9);
      for (int t = 3; t <= 8; t++) tick();
      chk("snap_flags", {rdy2, busy2}, 2'b10);
      chk("snap_result", c2, basic_c);

      // Enable handshake: hold enable through DONE
      a2 = pack2(32'd1, 32'd2, 32'd3, 32'd4);
      start2(1'b1);
      for (int t = 1; t <= 8; t++) tick();
      chk("hold_done", {rdy2, busy2, c2}, {2'b10, basic_c});
      for (int t = 1; t <= 20; t++) begin
         tick();
         chk($sformatf("hold_stable_%0d", t), {rdy2, busy2, c2}, {2'b10, basic_c});
      end
      a2 = pack2(32'd2, 32'd0, 32'd0, 32'd2);
      en2 = 1'b0;
      tick();
      chk("drop_idle_rdy_kept", {rdy2, busy2, c2}, {2'b10, basic_c});
      en2 = 1'b1;
      tick();
      en2 = 1'b0;
      chk("restart_cleared", {rdy2, busy2, c2}, {2'b01, 128'd0});
      for (int t = 1; t <= 8; t++) tick();
      chk("restart_result", {rdy2, busy2, c2},
          {2'b10, pack2(32'd10, 32'd12, 32'd14, 32'd16)});

      // Reset mid-run at E+4
      a2 = pack2(32'd1, 32'd2, 32'd3, 32'd4);
      start2(1'b0);
      tick();
      tick();
      tick();
      chk("midrun_c00_before_reset", c2, pack2(32'd19, 32'd0, 32'd0, 32'd0));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrun_reset", {rdy2, busy2, c2}, {2'b00, 128'd0});
      a2 = pack2(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
      b2 = pack2(32'd2, 32'd0, 32'd3, 32'd0);
      en2 = 1'b1;
      tick();
      en2 = 1'b0;
      chk("post_reset_start", {rdy2, busy2}, 2'b01);
      for (int t = 1; t <= 8; t++) tick();
      chk("post_reset_result", {rdy2, busy2, c2},
          {2'b10, pack2(32'hFFFF_FFFB, 32'd0, 32'd0, 32'd0)});

      // Parameter sweep: order 3, 16-bit, identity x B
      a3 = {16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1};
      b3 = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
      en3 = 1'b1;
      tick();
      en3 = 1'b0;
      chk("sweep_start", {rdy3, busy3}, 2'b01);
      for (int t = 1; t <= 26; t++) tick();
      chk("sweep_busy_E+26", {rdy3, busy3}, 2'b01);
      tick();
      chk("sweep_done_E+27", {rdy3, busy3}, 2'b10);
      chk("sweep_result", c3, b3);
      saved_c = c2;
      chk("u2_untouched_by_sweep", {rdy2, busy2, saved_c},
          {2'b10, pack2(32'hFFFF_FFFB, 32'd0, 32'd0, 32'd0)});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
